// File: rtl/fmult_pred_accum_if.sv
// Operand/result bundle for the predictor-sum engine.
// The master drives the start request and operand buses; the slave returns status and estimates.
interface fmult_pred_accum_if #(
  parameter int N_ZERO = 6,
  parameter int N_POLE = 2
);
  logic                   I_START;
  logic [16*N_ZERO-1:0]   I_COEF_B;
  logic [11*N_ZERO-1:0]   I_DQ;
  logic [16*N_POLE-1:0]   I_COEF_A;
  logic [11*N_POLE-1:0]   I_SR;
  logic                   O_BUSY;
  logic                   O_DONE;
  logic [14:0]            O15_SEZ;
  logic [14:0]            O15_SE;

  modport master (
    output I_START, I_COEF_B, I_DQ, I_COEF_A, I_SR,
    input  O_BUSY, O_DONE, O15_SEZ, O15_SE
  );

  modport slave (
    input  I_START, I_COEF_B, I_DQ, I_COEF_A, I_SR,
    output O_BUSY, O_DONE, O15_SEZ, O15_SE
  );
endinterface

// File: rtl/fmult_pred_accum.sv
// Sequential ADPCM predictor sum: one shared float multiplier walks the zero-section
// terms and then the pole-section terms, one per clock, into a 16-bit wrapping accumulator.
module fmult_pred_accum #(
  parameter int N_ZERO = 6,
  parameter int N_POLE = 2,
  parameter int CNT_W  = 4
) (
  input  logic              clk,
  input  logic              reset,
  fmult_pred_accum_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ZERO,
    S_POLE,
    S_DONE
  } state_t;

  state_t           state_reg;
  logic [CNT_W-1:0] idx_reg;
  logic [15:0]      acc_reg;
  logic             busy_reg;
  logic             done_reg;
  logic [14:0]      sez_reg;
  logic [14:0]      se_reg;

  logic [15:0] coef_b_reg [N_ZERO];
  logic [10:0] dq_reg     [N_ZERO];
  logic [15:0] coef_a_reg [N_POLE];
  logic [10:0] sr_reg     [N_POLE];

  // Unpacked views of the operand buses so the latch loop stays index-simple.
  logic [15:0] coef_b_in [N_ZERO];
  logic [10:0] dq_in     [N_ZERO];
  logic [15:0] coef_a_in [N_POLE];
  logic [10:0] sr_in     [N_POLE];

  genvar gi;
  generate
    for (gi = 0; gi < N_ZERO; gi++) begin : g_zero_in
      assign coef_b_in[gi] = bus.I_COEF_B[16*gi +: 16];
      assign dq_in[gi]     = bus.I_DQ[11*gi +: 11];
    end
    for (gi = 0; gi < N_POLE; gi++) begin : g_pole_in
      assign coef_a_in[gi] = bus.I_COEF_A[16*gi +: 16];
      assign sr_in[gi]     = bus.I_SR[11*gi +: 11];
    end
  endgenerate

  logic [15:0] coef_sel;
  logic [10:0] flt_sel;

  always_comb begin
    coef_sel = 16'd0;
    flt_sel  = 11'd0;
    if (state_reg == S_ZERO) begin
      for (int i = 0; i < N_ZERO; i++) begin
        if (idx_reg == CNT_W'(i)) begin
          coef_sel = coef_b_reg[i];
          flt_sel  = dq_reg[i];
        end
      end
    end else if (state_reg == S_POLE) begin
      for (int i = 0; i < N_POLE; i++) begin
        if (idx_reg == CNT_W'(i)) begin
          coef_sel = coef_a_reg[i];
          flt_sel  = sr_reg[i];
        end
      end
    end
  end

  // Coefficient to sign/exponent/mantissa; the two LSBs carry no weight in the product.
  logic        s1;
  logic [13:0] mag;
  logic [3:0]  e1;
  logic [5:0]  m1;
  logic [19:0] mag_ext;
  logic        unused_coef_lsbs;

  assign s1               = coef_sel[15];
  assign mag              = s1 ? 14'(14'd0 - coef_sel[15:2]) : coef_sel[15:2];
  assign mag_ext          = {mag, 6'b0};
  assign unused_coef_lsbs = ^coef_sel[1:0];

  always_comb begin
    e1 = 4'd0;
    for (int i = 0; i < 12; i++) begin
      if (mag[i]) begin
        e1 = 4'(i + 1);
      end
    end
    if (mag[13] | mag[12]) begin
      e1 = 4'd13;
    end
  end

  assign m1 = (mag == 14'd0) ? 6'd32 : 6'(mag_ext >> e1);

  logic        s2;
  logic [3:0]  e2;
  logic [5:0]  m2;
  logic [4:0]  e_sum;
  logic [12:0] mm_wide;
  logic [7:0]  mm;
  logic [31:0] mm_base;
  logic [15:0] pmag;
  logic [15:0] prod;
  logic [15:0] sum;

  assign s2      = flt_sel[10];
  assign e2      = flt_sel[9:6];
  assign m2      = flt_sel[5:0];
  assign e_sum   = {1'b0, e1} + {1'b0, e2};
  assign mm_wide = 13'(m1 * m2) + 13'd48;
  assign mm      = 8'(mm_wide >> 4);
  assign mm_base = {17'd0, mm, 7'd0};

  // Exponent 26 is the unity point of the product scaling; above it the result shifts up and truncates.
  always_comb begin
    if (e_sum <= 5'd26) begin
      pmag = 16'(mm_base >> (5'd26 - e_sum));
    end else begin
      pmag = 16'(mm_base << (e_sum - 5'd26));
    end
  end

  assign prod = (s1 ^ s2) ? 16'(16'd0 - pmag) : pmag;
  assign sum  = acc_reg + prod;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= S_IDLE;
      idx_reg   <= '0;
      acc_reg   <= '0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
      sez_reg   <= '0;
      se_reg    <= '0;
      for (int i = 0; i < N_ZERO; i++) begin
        coef_b_reg[i] <= '0;
        dq_reg[i]     <= '0;
      end
      for (int i = 0; i < N_POLE; i++) begin
        coef_a_reg[i] <= '0;
        sr_reg[i]     <= '0;
      end
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          if (bus.I_START) begin
            for (int i = 0; i < N_ZERO; i++) begin
              coef_b_reg[i] <= coef_b_in[i];
              dq_reg[i]     <= dq_in[i];
            end
            for (int i = 0; i < N_POLE; i++) begin
              coef_a_reg[i] <= coef_a_in[i];
              sr_reg[i]     <= sr_in[i];
            end
            acc_reg   <= '0;
            idx_reg   <= '0;
            busy_reg  <= 1'b1;
            state_reg <= S_ZERO;
          end
        end
        S_ZERO: begin
          acc_reg <= sum;
          if (idx_reg == CNT_W'(N_ZERO - 1)) begin
            sez_reg   <= sum[15:1];
            idx_reg   <= '0;
            state_reg <= S_POLE;
          end else begin
            idx_reg <= idx_reg + 1'b1;
          end
        end
        S_POLE: begin
          acc_reg <= sum;
          if (idx_reg == CNT_W'(N_POLE - 1)) begin
            idx_reg   <= '0;
            state_reg <= S_DONE;
          end else begin
            idx_reg <= idx_reg + 1'b1;
          end
        end
        S_DONE: begin
          se_reg    <= acc_reg[15:1];
          done_reg  <= 1'b1;
          busy_reg  <= 1'b0;
          state_reg <= S_IDLE;
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

  assign bus.O_BUSY  = busy_reg;
  assign bus.O_DONE  = done_reg;
  assign bus.O15_SEZ = sez_reg;
  assign bus.O15_SE  = se_reg;

endmodule

// File: tb/tb_fmult_pred_accum.sv
// Directed bench for fmult_pred_accum: expected estimates are queued at start and
// compared when O_DONE appears; a second instance covers a reduced term count.
module tb_fmult_pred_accum;

  logic clk;
  logic reset;

  fmult_pred_accum_if #(.N_ZERO(6), .N_POLE(2)) if0 ();
  fmult_pred_accum_if #(.N_ZERO(2), .N_POLE(1)) if1 ();

  fmult_pred_accum #(.N_ZERO(6), .N_POLE(2), .CNT_W(4)) u_dut0 (
    .clk   (clk),
    .reset (reset),
    .bus   (if0)
  );

  fmult_pred_accum #(.N_ZERO(2), .N_POLE(1), .CNT_W(2)) u_dut1 (
    .clk   (clk),
    .reset (reset),
    .bus   (if1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;
  logic [29:0] sb_q [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic scramble0();
    if0.I_COEF_B = {$urandom, $urandom, $urandom};
    if0.I_DQ     = 66'({$urandom, $urandom, $urandom});
    if0.I_COEF_A = $urandom;
    if0.I_SR     = 22'($urandom);
  endtask

  task automatic quiet0(input string tag, input int n);
    int d = 0;
    repeat (n) begin
      @(negedge clk);
      if (if0.O_DONE) d++;
    end
    check(tag, d, 0);
  endtask

  // One run on the 6/2 instance; optionally pulses I_START mid-ZERO with junk operands.
  task automatic run0(input string name, input logic [95:0] b, input logic [65:0] dq,
                      input logic [31:0] a, input logic [21:0] sr,
                      input logic [14:0] exp_sez, input logic [14:0] exp_se, input bit inject);
    int k = 0;
    int busy_n = 0;
    bit seen = 0;
    logic [29:0] exp;
    @(negedge clk);
    if0.I_COEF_B = b; if0.I_DQ = dq; if0.I_COEF_A = a; if0.I_SR = sr;
    if0.I_START = 1'b1;
    sb_q.push_back({exp_sez, exp_se});
    @(negedge clk);
    if0.I_START = 1'b0;
    scramble0();
    while (k < 30 && !seen) begin
      if (if0.O_DONE) begin
        seen = 1;
      end else begin
        if (if0.O_BUSY) busy_n++;
        if0.I_START = (inject && k == 2);
        @(negedge clk);
        k++;
      end
    end
    check({name, " done_seen"}, 32'(seen), 1);
    check({name, " latency"}, k, 9);
    check({name, " busy_cycles"}, busy_n, 9);
    exp = sb_q.pop_front();
    check({name, " sez"}, 32'(if0.O15_SEZ), 32'(exp[29:15]));
    check({name, " se"}, 32'(if0.O15_SE), 32'(exp[14:0]));
    $display("run %s: latency %0d sez 0x%0h se 0x%0h", name, k, if0.O15_SEZ, if0.O15_SE);
    quiet0({name, " no_extra_done"}, 12);
  endtask

  localparam logic [95:0] B_ZERO  = 96'h0;
  localparam logic [95:0] B_T1    = {16'h0, 16'h0, 16'h0, 16'h0, 16'h4000, 16'h0};
  localparam logic [95:0] B_T1N   = {16'h0, 16'h0, 16'h0, 16'h0, 16'hC000, 16'h0};
  localparam logic [65:0] DQ_BASE = {6{11'h020}};
  localparam logic [65:0] DQ_T1   = {11'h020, 11'h020, 11'h020, 11'h020, 11'h2A0, 11'h020};
  localparam logic [31:0] A_ZERO  = 32'h0;
  localparam logic [31:0] A_T1    = {16'h4000, 16'h0};
  localparam logic [21:0] SR_BASE = {2{11'h020}};
  localparam logic [21:0] SR_T1   = {11'h2A0, 11'h020};

  initial begin
    int k;
    int busy_n;
    int nd;
    int dpos [3];
    bit seen;
    logic [29:0] exp;

    reset = 1'b1;
    if0.I_START = 1'b0; if0.I_COEF_B = '0; if0.I_DQ = '0; if0.I_COEF_A = '0; if0.I_SR = '0;
    if1.I_START = 1'b0; if1.I_COEF_B = '0; if1.I_DQ = '0; if1.I_COEF_A = '0; if1.I_SR = '0;
    repeat (2) @(negedge clk);
    check("reset busy", 32'(if0.O_BUSY), 0);
    check("reset done", 32'(if0.O_DONE), 0);
    check("reset sez", 32'(if0.O15_SEZ), 0);
    check("reset se", 32'(if0.O15_SE), 0);
    reset = 1'b0;

    run0("all_zero", B_ZERO, DQ_BASE, A_ZERO, SR_BASE, 15'h000, 15'h000, 0);
    run0("zero_term", B_T1, DQ_T1, A_ZERO, SR_BASE, 15'h218, 15'h218, 0);
    run0("zero_pole", B_T1, DQ_T1, A_T1, SR_T1, 15'h218, 15'h430, 0);
    run0("neg_coef", B_T1N, DQ_T1, A_ZERO, SR_BASE, 15'h7DE8, 15'h7DE8, 0);
    // Exponent 28 shifts past bit 15: 66048 truncates to 512.
    run0("trunc", {80'h0, 16'h4000}, {DQ_BASE[65:11], 11'h3FF}, A_ZERO, SR_BASE,
         15'h100, 15'h100, 0);
    // Negative float against positive coef, then negative against negative cancels.
    run0("neg_float", {80'h0, 16'h4000}, {DQ_BASE[65:11], 11'h6A0}, {16'h0, 16'hC000},
         {11'h020, 11'h6A0}, 15'h7DE8, 15'h000, 0);
    run0("inject_mid", B_T1, DQ_T1, A_T1, SR_T1, 15'h218, 15'h430, 1);

    // I_START held high: back-to-back runs one every 10 cycles.
    @(negedge clk);
    if0.I_COEF_B = B_T1; if0.I_DQ = DQ_T1; if0.I_COEF_A = A_T1; if0.I_SR = SR_T1;
    if0.I_START = 1'b1;
    repeat (3) sb_q.push_back({15'h218, 15'h430});
    k = 0; nd = 0;
    while (k < 60 && nd < 3) begin
      @(negedge clk);
      if (if0.O_DONE) begin
        dpos[nd] = k;
        exp = sb_q.pop_front();
        check("cont sez", 32'(if0.O15_SEZ), 32'(exp[29:15]));
        check("cont se", 32'(if0.O15_SE), 32'(exp[14:0]));
        $display("cont done %0d at cycle %0d se 0x%0h", nd, k, if0.O15_SE);
        nd++;
        if (nd == 3) if0.I_START = 1'b0;
      end
      k++;
    end
    check("cont done_count", nd, 3);
    if (nd == 3) begin
      check("cont first", dpos[0], 9);
      check("cont gap1", dpos[1] - dpos[0], 10);
      check("cont gap2", dpos[2] - dpos[1], 10);
    end
    if0.I_START = 1'b0;
    quiet0("cont stop", 15);
    check("cont idle busy", 32'(if0.O_BUSY), 0);

    // Abort during POLE with asynchronous reset.
    @(negedge clk);
    if0.I_START = 1'b1;
    @(negedge clk);
    if0.I_START = 1'b0;
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (if0.O_DONE) seen = 1;
    end
    check("abort busy_before", 32'(if0.O_BUSY), 1);
    reset = 1'b1;
    #1;
    check("abort busy", 32'(if0.O_BUSY), 0);
    check("abort done", 32'(if0.O_DONE), 0);
    check("abort sez", 32'(if0.O15_SEZ), 0);
    check("abort se", 32'(if0.O15_SE), 0);
    check("abort early_done", 32'(seen), 0);
    $display("abort: outputs after reset sez 0x%0h se 0x%0h", if0.O15_SEZ, if0.O15_SE);
    @(negedge clk);
    reset = 1'b0;
    quiet0("abort no_done", 15);
    run0("after_abort", B_T1, DQ_T1, A_T1, SR_T1, 15'h218, 15'h430, 0);

    // Reduced instance: 2 zero terms, 1 pole term.
    @(negedge clk);
    if1.I_COEF_B = {16'h4000, 16'h0}; if1.I_DQ = {11'h2A0, 11'h020};
    if1.I_COEF_A = 16'h4000; if1.I_SR = 11'h2A0;
    if1.I_START = 1'b1;
    sb_q.push_back({15'h218, 15'h430});
    @(negedge clk);
    if1.I_START = 1'b0;
    if1.I_COEF_B = $urandom; if1.I_DQ = 22'($urandom);
    if1.I_COEF_A = 16'($urandom); if1.I_SR = 11'($urandom);
    k = 0; busy_n = 0; seen = 0;
    while (k < 20 && !seen) begin
      if (if1.O_DONE) begin
        seen = 1;
      end else begin
        if (if1.O_BUSY) busy_n++;
        @(negedge clk);
        k++;
      end
    end
    check("small done_seen", 32'(seen), 1);
    check("small latency", k, 4);
    check("small busy_cycles", busy_n, 4);
    exp = sb_q.pop_front();
    check("small sez", 32'(if1.O15_SEZ), 32'(exp[29:15]));
    check("small se", 32'(if1.O15_SE), 32'(exp[14:0]));
    $display("run small: latency %0d sez 0x%0h se 0x%0h", k, if1.O15_SEZ, if1.O15_SE);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
